// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter state encoding and index-width helpers
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // A single channel still needs a one-bit index port.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - cyclic next-requester search starting after pointer
module rr_select
    import arb_pkg::*;
#(
    parameter  int WIDTH = 6,
    localparam int IW    = idx_bits(WIDTH)
) (
    input  logic [WIDTH-1:0] request,
    input  logic [WIDTH-1:0] mask,
    input  logic [IW-1:0]    pointer,
    output logic [IW-1:0]    index,
    output logic             valid
);

    logic [WIDTH-1:0] eligible;
    int               cand;

    // Walk from farthest to nearest so the nearest eligible channel wins.
    always_comb begin
        eligible = request & mask;
        index    = '0;
        valid    = 1'b0;
        cand     = 0;
        for (int k = WIDTH; k >= 1; k--) begin
            cand = int'(pointer) + k;
            if (cand >= WIDTH) cand = cand - WIDTH;
            if (eligible[cand]) begin
                index = IW'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - round-robin FWFT source arbiter with burst/hold ownership
module stream_arbiter
    import arb_pkg::*;
#(
    parameter  int WIDTH     = 6,
    parameter  int DSIZE     = 32,
    parameter  int MAX_BURST = 16,
    localparam int IW        = idx_bits(WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [WIDTH-1:0]       WRITE_REQ,
    input  logic [WIDTH-1:0]       HOLD_REQ,
    input  logic [WIDTH-1:0]       ENABLE_MASK,
    input  logic [WIDTH*DSIZE-1:0] DATA_IN,
    output logic [WIDTH-1:0]       READ_GRANT,
    output logic [DSIZE-1:0]       DATA_OUT,
    output logic [IW-1:0]          CH_ID,
    output logic                   WRITE_OUT,
    input  logic                   READY_IN
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_owner_q, last_owner_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DSIZE-1:0] data_q, data_d;
    logic [IW-1:0]    ch_id_q, ch_id_d;

    logic [IW-1:0]    sel_index;
    logic             sel_valid;
    logic             own_req, own_hold, own_en, out_free, burst_done, grant;

    rr_select #(.WIDTH(WIDTH)) u_rr_select (
        .request (WRITE_REQ),
        .mask    (ENABLE_MASK),
        .pointer (last_owner_q),
        .index   (sel_index),
        .valid   (sel_valid)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        ch_id_d      = ch_id_q;
        READ_GRANT   = '0;
        grant        = 1'b0;

        own_req    = WRITE_REQ[owner_q];
        own_hold   = HOLD_REQ[owner_q];
        own_en     = ENABLE_MASK[owner_q];
        out_free   = !out_valid_q || READY_IN;
        burst_done = int'(burst_cnt_q) >= MAX_BURST;

        if (out_valid_q && READY_IN) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d     = ST_OWN;
                    owner_d     = sel_index;
                    burst_cnt_d = '0;
                end
            end
            ST_OWN: begin
                // A held owner may keep popping past the burst limit.
                grant = own_req && own_en && out_free && (own_hold || !burst_done);
                if (grant) begin
                    READ_GRANT[owner_q] = 1'b1;
                    out_valid_d         = 1'b1;
                    data_d              = DATA_IN[int'(owner_q)*DSIZE +: DSIZE];
                    ch_id_d             = owner_q;
                    if (burst_cnt_q != 8'hFF) burst_cnt_d = burst_cnt_q + 8'd1;
                end
                if (!own_en || (!own_hold && (!own_req || int'(burst_cnt_d) >= MAX_BURST))) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(WIDTH - 1);
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            ch_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            ch_id_q      <= ch_id_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign CH_ID     = ch_id_q;
    assign WRITE_OUT = out_valid_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// tb/tb_stream_arbiter.sv - randomized scoreboard bench for stream_arbiter
module tb_stream_arbiter;

    localparam int W  = 6;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [W-1:0]    WRITE_REQ = '0;
    logic [W-1:0]    HOLD_REQ = '0;
    logic [W-1:0]    ENABLE_MASK = '1;
    logic [W*DW-1:0] DATA_IN = '0;
    logic [W-1:0]    READ_GRANT;
    logic [DW-1:0]   DATA_OUT;
    logic [2:0]      CH_ID;
    logic            WRITE_OUT;
    logic            READY_IN = 1'b1;

    stream_arbiter #(.WIDTH(W), .DSIZE(DW), .MAX_BURST(MB)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .WRITE_REQ   (WRITE_REQ),
        .HOLD_REQ    (HOLD_REQ),
        .ENABLE_MASK (ENABLE_MASK),
        .DATA_IN     (DATA_IN),
        .READ_GRANT  (READ_GRANT),
        .DATA_OUT    (DATA_OUT),
        .CH_ID       (CH_ID),
        .WRITE_OUT   (WRITE_OUT),
        .READY_IN    (READY_IN)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] src_q [W][$];
    logic [DW-1:0] exp_q [W][$];
    int            pops [W];
    int            dlv [W];
    int            delivered;
    int            cyc;
    int            gch;
    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  hold_v, mask_v, gate;
    bit            rand_ready;
    logic          ready_v;
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic [2:0]    prev_id;

    task automatic clear_model();
        for (int i = 0; i < W; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            pops[i] = 0;
            dlv[i]  = 0;
        end
        delivered  = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        hold_v     = '0;
        mask_v     = '1;
        gate       = '0;
        rand_ready = 1'b0;
        ready_v    = 1'b1;
    endtask

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) src_q[ch].push_back({8'(ch), 24'($urandom)});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N     = 1'b0;
        WRITE_REQ = '0;
        HOLD_REQ  = '0;
        clear_model();
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask

    // One clock: drive source FIFO fronts, sample just before the edge, update the model.
    task automatic run_cycle();
        logic [W-1:0] g;
        int           ch;
        @(negedge CLK);
        for (int i = 0; i < W; i++) begin
            WRITE_REQ[i] = (src_q[i].size() != 0) && !gate[i];
            DATA_IN[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
        HOLD_REQ    = hold_v;
        ENABLE_MASK = mask_v;
        READY_IN    = rand_ready ? 1'($urandom_range(0, 1)) : ready_v;
        #4;
        g   = READ_GRANT;
        gch = -1;
        checks++;
        if (!$onehot0(g)) begin
            errors++;
            $display("FAIL grant_onehot cyc=%0d got %b want at most one bit", cyc, g);
        end
        for (int i = 0; i < W; i++) if (g[i]) gch = i;
        if (gch >= 0) begin
            checks++;
            if (!(WRITE_REQ[gch] && ENABLE_MASK[gch])) begin
                errors++;
                $display("FAIL grant_legal cyc=%0d got grant ch %0d want requesting enabled channel", cyc, gch);
            end else begin
                exp_q[gch].push_back(src_q[gch].pop_front());
                pops[gch]++;
            end
        end
        if (stall_prev) begin
            checks++;
            if (WRITE_OUT !== 1'b1 || DATA_OUT !== prev_data || CH_ID !== prev_id) begin
                errors++;
                $display("FAIL stall_stable cyc=%0d got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                         cyc, WRITE_OUT, DATA_OUT, CH_ID, prev_data, prev_id);
            end
        end
        if (WRITE_OUT === 1'b1 && READY_IN) begin
            ch = int'(CH_ID);
            checks++;
            if (ch >= W || exp_q[ch].size() == 0) begin
                errors++;
                $display("FAIL spurious_word cyc=%0d got ch %0d d=%h want no word", cyc, ch, DATA_OUT);
            end else begin
                if (DATA_OUT !== exp_q[ch][0]) begin
                    errors++;
                    $display("FAIL word_order cyc=%0d ch=%0d got %h want %h", cyc, ch, DATA_OUT, exp_q[ch][0]);
                end
                void'(exp_q[ch].pop_front());
                dlv[ch]++;
                delivered++;
            end
        end
        stall_prev = (WRITE_OUT === 1'b1) && !READY_IN;
        prev_data  = DATA_OUT;
        prev_id    = CH_ID;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        clear_model();
        #1;
        checks++;
        if (WRITE_OUT !== 1'b0 || DATA_OUT !== '0 || CH_ID !== '0 || READ_GRANT !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h id=%0d g=%b want all zero", WRITE_OUT, DATA_OUT, CH_ID, READ_GRANT);
        end
        @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (3) begin
            run_cycle();
            checks++;
            if (gch != -1 || WRITE_OUT !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got grant %0d v=%b want none", gch, WRITE_OUT);
            end
        end
    endtask

    task automatic test_round_robin();
        int gseq[$];
        int gcyc[$];
        int s;
        do_reset();
        for (int i = 0; i < W; i++) load(i, 20);
        while (delivered < 120 && cyc < 600) begin
            s = cyc;
            run_cycle();
            if (gch >= 0) begin
                gseq.push_back(gch);
                gcyc.push_back(s);
            end
        end
        checks++;
        if (delivered != 120 || gseq.size() != 120) begin
            errors++;
            $display("FAIL rr_total got delivered=%0d grants=%0d want 120", delivered, gseq.size());
        end else begin
            checks++;
            if (gcyc[0] != 1) begin
                errors++;
                $display("FAIL rr_first_latency got cycle %0d want 1", gcyc[0]);
            end
            for (int k = 0; k < 120; k++) begin
                checks++;
                if (gseq[k] != (k / MB) % W || gcyc[k] - gcyc[0] != (k / MB) * (MB + 1) + k % MB) begin
                    errors++;
                    $display("FAIL rr_sequence k=%0d got ch %0d at +%0d want ch %0d at +%0d", k, gseq[k],
                             gcyc[k] - gcyc[0], (k / MB) % W, (k / MB) * (MB + 1) + k % MB);
                end
            end
        end
    endtask

    task automatic test_hold();
        int gap_left, drop_cyc, first1, s;
        bit gap_done;
        do_reset();
        load(0, 10);
        load(1, 5);
        hold_v   = 6'b000001;
        gap_left = 0;
        gap_done = 0;
        drop_cyc = -1;
        first1   = -1;
        while (delivered < 15 && cyc < 300) begin
            gate[0] = (gap_left > 0);
            if (pops[0] == 10 && drop_cyc < 0) begin
                hold_v[0] = 1'b0;
                drop_cyc  = cyc;
            end
            s = cyc;
            run_cycle();
            if (gap_left > 0) gap_left--;
            if (pops[0] == 5 && !gap_done) begin
                gap_left = 3;
                gap_done = 1;
            end
            if (gch == 1 && first1 < 0) begin
                first1 = s;
                checks++;
                if (pops[0] != 10 || drop_cyc < 0) begin
                    errors++;
                    $display("FAIL hold_preempted got ch1 grant after %0d ch0 words want 10", pops[0]);
                end
            end
        end
        checks++;
        if (dlv[0] != 10 || dlv[1] != 5) begin
            errors++;
            $display("FAIL hold_delivered got ch0=%0d ch1=%0d want 10 5", dlv[0], dlv[1]);
        end
        checks++;
        if (drop_cyc < 0 || first1 != drop_cyc + 2) begin
            errors++;
            $display("FAIL hold_handover got ch1 at %0d want %0d", first1, drop_cyc + 2);
        end
    endtask

    task automatic test_random_backpressure();
        int total;
        do_reset();
        total = 0;
        for (int i = 0; i < W; i++) begin
            int n;
            n = $urandom_range(5, 15);
            load(i, n);
            total += n;
        end
        rand_ready = 1'b1;
        while (delivered < total && cyc < 3000) run_cycle();
        checks++;
        if (delivered != total) begin
            errors++;
            $display("FAIL random_count got %0d want %0d", delivered, total);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (exp_q[i].size() != 0 || src_q[i].size() != 0) begin
                errors++;
                $display("FAIL random_drain ch=%0d got pending %0d/%0d want 0/0", i, src_q[i].size(), exp_q[i].size());
            end
        end
    endtask

    task automatic test_mask();
        int mcyc, first3, s;
        do_reset();
        load(2, 8);
        load(3, 4);
        hold_v = 6'b000100;
        mcyc   = -1;
        first3 = -1;
        while (delivered < 6 && cyc < 200) begin
            if (pops[2] == 2 && mcyc < 0) begin
                mask_v[2] = 1'b0;
                mcyc      = cyc;
            end
            s = cyc;
            run_cycle();
            if (gch == 3 && first3 < 0) first3 = s;
        end
        checks++;
        if (pops[2] != 2 || dlv[2] != 2 || dlv[3] != 4) begin
            errors++;
            $display("FAIL mask_words got ch2 pops=%0d dlv=%0d ch3 dlv=%0d want 2 2 4", pops[2], dlv[2], dlv[3]);
        end
        checks++;
        if (mcyc < 0 || first3 != mcyc + 2) begin
            errors++;
            $display("FAIL mask_release got ch3 first grant at %0d want %0d", first3, mcyc + 2);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load(3, 6);
        ready_v = 1'b0;
        repeat (4) run_cycle();
        checks++;
        if (WRITE_OUT !== 1'b1 || CH_ID !== 3'd3) begin
            errors++;
            $display("FAIL midburst_setup got v=%b id=%0d want v=1 id=3", WRITE_OUT, CH_ID);
        end
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if (WRITE_OUT !== 1'b0 || DATA_OUT !== '0 || CH_ID !== '0 || READ_GRANT !== '0) begin
            errors++;
            $display("FAIL midburst_async got v=%b d=%h id=%0d g=%b want all zero", WRITE_OUT, DATA_OUT, CH_ID, READ_GRANT);
        end
        clear_model();
        load(0, 3);
        load(3, 3);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        run_cycle();
        checks++;
        if (gch != -1) begin
            errors++;
            $display("FAIL midburst_first_cycle got grant ch %0d want none", gch);
        end
        run_cycle();
        checks++;
        if (gch != 0) begin
            errors++;
            $display("FAIL midburst_winner got grant ch %0d want 0", gch);
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_round_robin();
        test_hold();
        test_random_backpressure();
        test_mask();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
